// File: rtl/writeback_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU and load results,
// with a registered write stage and a per-register busy scoreboard; `WB_ARB_STATS_EN adds a conflict counter.
module writeback_arbiter #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic [ADDR_W-1:0] src0_num,
  input  logic [ADDR_W-1:0] src1_num,
  output logic              hazard,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic [ADDR_W-1:0] reg_num_w,
  output logic [DATA_W-1:0] w_data,
  output logic              ctrl_reg_w
`ifdef WB_ARB_STATS_EN
  ,
  output logic [15:0]       conflict_count
`endif
);

  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_MEM = 1'b1;

  logic              last_grant_q, last_grant_d;
  logic              grant_alu, grant_mem;
  logic [ADDR_W-1:0] sel_rd;
  logic [DATA_W-1:0] sel_data;
  logic              wr_en_d, wr_en_q;
  logic [ADDR_W-1:0] reg_num_w_q;
  logic [DATA_W-1:0] w_data_q;
  logic [NUM_REGS-1:0] busy_q, busy_d;

  always_comb begin
    grant_alu    = alu_valid && (!mem_valid || (last_grant_q == SRC_MEM));
    grant_mem    = mem_valid && !grant_alu;
    last_grant_d = last_grant_q;
    if (grant_alu)      last_grant_d = SRC_ALU;
    else if (grant_mem) last_grant_d = SRC_MEM;
    sel_rd   = grant_mem ? mem_rd   : alu_rd;
    sel_data = grant_mem ? mem_data : alu_data;
    // x0 requests are consumed but never reach the register file
    wr_en_d  = (grant_alu || grant_mem) && (sel_rd != '0);
  end

  assign alu_ready = grant_alu;
  assign mem_ready = grant_mem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= SRC_MEM;
      wr_en_q      <= 1'b0;
      reg_num_w_q  <= '0;
      w_data_q     <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      wr_en_q      <= wr_en_d;
      if (grant_alu || grant_mem) begin
        reg_num_w_q <= sel_rd;
        w_data_q    <= sel_data;
      end
    end
  end

  assign ctrl_reg_w = wr_en_q;
  assign reg_num_w  = reg_num_w_q;
  assign w_data     = w_data_q;

  // Clear on the commit edge first so a same-cycle issue to that register wins
  always_comb begin
    busy_d = busy_q;
    if (wr_en_q) busy_d[reg_num_w_q] = 1'b0;
    if (issue_valid && (issue_rd != '0)) busy_d[issue_rd] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign hazard = ((src0_num != '0) && busy_q[src0_num]) ||
                  ((src1_num != '0) && busy_q[src1_num]);

`ifdef WB_ARB_STATS_EN
  logic [15:0] conflict_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      conflict_q <= '0;
    else if (alu_valid && mem_valid && (conflict_q != 16'hFFFF))
      conflict_q <= conflict_q + 16'd1;
  end

  assign conflict_count = conflict_q;
`endif

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Shares the register file's single write port between two writeback sources: ALU results and load (memory) results.
- Uses round-robin arbitration and a registered write stage.
- Holds a per-register busy scoreboard. Decode uses it to stall on read-after-write hazards.
- Sits between the execute/memory units and the register file. Its registered outputs drive the register file's write-select, write-data and write-enable inputs directly.

Parameters:
- ADDR_W, default REGISTER_FILE_ADDRESS_WIDTH (5): register index width.
- DATA_W, default RISC_V_DATA_WIDTH (64): write data width.
- NUM_REGS, default REGISTER_FILE_NUM (32): scoreboard depth; must equal 2**ADDR_W.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- issue_valid  in  1  instruction issued that will write issue_rd
- issue_rd  in  ADDR_W  destination register of the issued instruction
- src0_num  in  ADDR_W  first operand register of the instruction in decode
- src1_num  in  ADDR_W  second operand register of the instruction in decode
- hazard  out  1  one or both operands have a pending write
- alu_valid  in  1  ALU result request
- alu_ready  out  1  ALU request accepted this cycle
- alu_rd  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- mem_valid  in  1  load result request
- mem_ready  out  1  load request accepted this cycle
- mem_rd  in  ADDR_W  load destination register
- mem_data  in  DATA_W  load result
- reg_num_w  out  ADDR_W  register file write select (registered)
- w_data  out  DATA_W  register file write data (registered)
- ctrl_reg_w  out  1  register file write enable (registered)

Behaviour:
- Clock and reset: single clock domain on clk, rising edge. rst is asynchronous, active-high.
- Reset values: reg_num_w=0, w_data=0, ctrl_reg_w=0, all busy bits=0, last_grant=MEM (so the ALU wins the first conflict).
- Reset mid-operation: any staged write is dropped and all busy bits clear.
- Arbitration:
  - Only one source valid: that source is granted.
  - Both valid: the source not equal to last_grant is granted, then last_grant updates to the winner.
  - last_grant updates only on a conflict-free grant or a conflict grant. It holds when no source is valid.
- Ready:
  - alu_ready and mem_ready are combinational from the valids and last_grant. At most one is high per cycle.
  - A source is granted every cycle at least one valid is high, because the write stage never backpressures.
- Source protocol: a requester holds valid, rd and data stable until it sees ready.
- Write stage latency:
  - A grant in cycle N produces ctrl_reg_w=1, reg_num_w=rd and w_data=data in cycle N+1.
  - With no grant, ctrl_reg_w=0 in the next cycle. reg_num_w and w_data hold their previous values.
- x0 writes: a granted request with rd=0 is accepted (ready=1), but ctrl_reg_w stays 0 for it.
- Scoreboard:
  - busy[issue_rd] sets at the clock edge where issue_valid=1 and issue_rd!=0. busy[0] is never set.
  - busy[reg_num_w] clears at the edge that ends a cycle with ctrl_reg_w=1, i.e. the same edge the register file commits the write.
  - Set and clear hit the same register in the same cycle: set wins.
  - Clears and sets to different registers in the same cycle both take effect.
- hazard: combinational, (src0_num!=0 && busy[src0_num]) || (src1_num!=0 && busy[src1_num]). No bypass of the staged write; hazard stays high until the commit edge.
- Scoreboard model: a single pending writer per register. Issue of a second writer to a busy register is the decode stage's responsibility to prevent; no queueing is provided.

Optional Feature:
- Macro: WB_ARB_STATS_EN.
- Defined:
  - Adds output port conflict_count, out, 16 bits.
  - conflict_count increments in each cycle where alu_valid and mem_valid are both high, and saturates at 16'hFFFF.
  - Reset value is 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: assert rst with ctrl_reg_w high -> ctrl_reg_w, reg_num_w, w_data, hazard and all busy bits read 0 immediately (async).
- Single ALU write: alu_valid=1, alu_rd=5, alu_data=0x1234 in cycle N -> alu_ready=1 in N; ctrl_reg_w=1, reg_num_w=5, w_data=0x1234 in N+1; ctrl_reg_w=0 in N+2.
- Conflict: both valid for 3 cycles after reset, ALU rd=1 and MEM rd=2 -> grants ALU, MEM, ALU. Write stage shows rd 1, 2, 1. Each source holds valid until its own ready.
- Scoreboard: issue rd=7, then src0_num=7 -> hazard=1. ALU writeback of rd 7 -> hazard stays 1 through the ctrl_reg_w cycle and drops to 0 the cycle after.
- x0 handling: issue_rd=0, then src1_num=0 -> hazard=0. MEM write with rd=0 -> mem_ready=1, ctrl_reg_w stays 0.
- Set/clear collision: a commit to rd=9 and issue_valid with issue_rd=9 in the same cycle -> busy[9] remains 1 and hazard on src0_num=9 stays 1.
